// File: rtl/matrix_op_mul_gen.sv
// rtl/matrix_op_mul_gen.sv - parametrised matrix multiply engine, C = A x B or A x B^T
// Define MATRIX_MUL_SAT_EN to clamp results to the element range and report sat_flag.
module matrix_op_mul_gen #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 12,
  parameter int DIM_WIDTH     = 5,
  parameter int MAX_DIM       = 16,
  parameter int ACC_WIDTH     = 24,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     sat_flag,
  input  logic                     signed_mode,
  input  logic                     transpose_b,
  input  logic [DIM_WIDTH-1:0]     dim_m,
  input  logic [DIM_WIDTH-1:0]     dim_n,
  input  logic [DIM_WIDTH-1:0]     dim_p,
  input  logic [ADDR_WIDTH-1:0]    addr_op1,
  input  logic [ADDR_WIDTH-1:0]    addr_op2,
  input  logic [ADDR_WIDTH-1:0]    addr_res,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [ELEMENT_WIDTH-1:0] mem_wr_data
);

  localparam int EW     = ELEMENT_WIDTH;
  localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(RD_LATENCY - 1);
  localparam logic [DIM_WIDTH-1:0] DIM_MAX   = DIM_WIDTH'(MAX_DIM);
  localparam logic [DIM_WIDTH-1:0] DIM_ONE   = DIM_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_INIT, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B, S_MAC, S_WRITE, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic                  r_sm, r_tb, r_err;
  logic [DIM_WIDTH-1:0]  r_m, r_n, r_p, r_i, r_j, r_k;
  logic [ADDR_WIDTH-1:0] r_base_a, r_base_b, r_base_c;
  logic [WAIT_W-1:0]     r_wait;
  logic [EW-1:0]         r_a, r_b;
  logic [ACC_WIDTH-1:0]  r_acc;

  logic                  w_accept, w_dims_bad, w_wait_last, w_k_last, w_j_last, w_i_last;
  logic [ADDR_WIDTH-1:0] w_addr_a, w_addr_b, w_addr_c;
  logic [2*EW-1:0]       w_a_x, w_b_x, w_prod;
  logic [ACC_WIDTH-1:0]  w_prod_ext;
  logic [EW-1:0]         w_conv;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_dims_bad  = (r_m == '0) || (r_n == '0) || (r_p == '0) ||
                       (r_m > DIM_MAX) || (r_n > DIM_MAX) || (r_p > DIM_MAX);
  assign w_wait_last = (r_wait == WAIT_LAST);
  assign w_k_last    = ((r_k + DIM_ONE) == r_p);
  assign w_j_last    = ((r_j + DIM_ONE) == r_n);
  assign w_i_last    = ((r_i + DIM_ONE) == r_m);

  // Row-major addressing; all sums wrap at the address width.
  assign w_addr_a = r_base_a + ADDR_WIDTH'(r_i) * ADDR_WIDTH'(r_p) + ADDR_WIDTH'(r_k);
  assign w_addr_b = r_tb ? (r_base_b + ADDR_WIDTH'(r_j) * ADDR_WIDTH'(r_p) + ADDR_WIDTH'(r_k))
                         : (r_base_b + ADDR_WIDTH'(r_k) * ADDR_WIDTH'(r_n) + ADDR_WIDTH'(r_j));
  assign w_addr_c = r_base_c + ADDR_WIDTH'(r_i) * ADDR_WIDTH'(r_n) + ADDR_WIDTH'(r_j);

  // Extending operands to 2*EW first makes the low half of the product correct for both modes.
  assign w_a_x  = r_sm ? {{EW{r_a[EW-1]}}, r_a} : {{EW{1'b0}}, r_a};
  assign w_b_x  = r_sm ? {{EW{r_b[EW-1]}}, r_b} : {{EW{1'b0}}, r_b};
  assign w_prod = w_a_x * w_b_x;

  generate
    if (ACC_WIDTH > 2 * EW) begin : g_prod_ext
      assign w_prod_ext = {{(ACC_WIDTH - 2 * EW){r_sm & w_prod[2*EW-1]}}, w_prod};
    end else begin : g_prod_same
      assign w_prod_ext = w_prod;
    end
  endgenerate

`ifdef MATRIX_MUL_SAT_EN
  logic w_fit_s, w_fit_u, w_clamp, r_sat;

  assign w_fit_s = (&r_acc[ACC_WIDTH-1:EW-1]) || !(|r_acc[ACC_WIDTH-1:EW-1]);
  assign w_fit_u = !(|r_acc[ACC_WIDTH-1:EW]);

  always_comb begin
    w_clamp = 1'b0;
    w_conv  = r_acc[EW-1:0];
    if (r_sm) begin
      if (!w_fit_s) begin
        w_clamp = 1'b1;
        w_conv  = r_acc[ACC_WIDTH-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
      end
    end else if (!w_fit_u) begin
      w_clamp = 1'b1;
      w_conv  = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_sat <= 1'b0;
    end else if ((r_state == S_WRITE) && w_clamp) begin
      r_sat <= 1'b1;
    end
  end

  assign sat_flag = r_sat;
`else
  logic w_unused_acc_hi;

  assign w_conv          = r_acc[EW-1:0];
  assign w_unused_acc_hi = ^r_acc[ACC_WIDTH-1:EW];
  assign sat_flag        = 1'b0;
`endif

  assign err = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CHECK;
      S_CHECK:  w_next = w_dims_bad ? S_DONE : S_INIT;
      S_INIT:   w_next = S_RD_A;
      S_RD_A: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = w_addr_a;
        w_next      = S_WAIT_A;
      end
      S_WAIT_A: if (w_wait_last) w_next = S_RD_B;
      S_RD_B: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = w_addr_b;
        w_next      = S_WAIT_B;
      end
      S_WAIT_B: if (w_wait_last) w_next = S_MAC;
      S_MAC:    w_next = w_k_last ? S_WRITE : S_RD_A;
      S_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = w_addr_c;
        mem_wr_data = w_conv;
        w_next      = (w_i_last && w_j_last) ? S_DONE : S_INIT;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sm     <= 1'b0;
      r_tb     <= 1'b0;
      r_err    <= 1'b0;
      r_m      <= '0;
      r_n      <= '0;
      r_p      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
      r_wait   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
    end else begin
      if (w_accept) begin
        r_sm     <= signed_mode;
        r_tb     <= transpose_b;
        r_m      <= dim_m;
        r_n      <= dim_n;
        r_p      <= dim_p;
        r_base_a <= addr_op1;
        r_base_b <= addr_op2;
        r_base_c <= addr_res;
        r_err    <= 1'b0;
      end
      case (r_state)
        S_CHECK: begin
          r_i <= '0;
          r_j <= '0;
          if (w_dims_bad) r_err <= 1'b1;
        end
        S_INIT: begin
          r_acc <= '0;
          r_k   <= '0;
        end
        S_WAIT_A: if (w_wait_last) r_a <= mem_rd_data;
        S_WAIT_B: if (w_wait_last) r_b <= mem_rd_data;
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (!w_k_last) r_k <= r_k + DIM_ONE;
        end
        S_WRITE: begin
          if (w_j_last) begin
            r_j <= '0;
            r_i <= r_i + DIM_ONE;
          end else begin
            r_j <= r_j + DIM_ONE;
          end
        end
        default: ;
      endcase
      if (((r_state == S_WAIT_A) || (r_state == S_WAIT_B)) && !w_wait_last) begin
        r_wait <= r_wait + WAIT_W'(1);
      end else begin
        r_wait <= '0;
      end
    end
  end

endmodule
